// File: rtl/fft_addr_if.sv
// fft_addr_if: bundle between the FFT address sequencer and its data RAM,
// twiddle ROM and butterfly unit.
interface fft_addr_if #(
  parameter int LOG2N = 3,
  parameter int TW_W  = 16
);
  localparam int SW = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);

  logic             start;
  logic             inverse;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_add1;
  logic [LOG2N-1:0] rd_add2;
  logic [LOG2N-2:0] tw_addr;
  logic [TW_W-1:0]  tw_re_in;
  logic [TW_W-1:0]  tw_im_in;
  logic [TW_W-1:0]  factor_re;
  logic [TW_W-1:0]  factor_im;
  logic             en_multi;
  logic             bf_done;
  logic             wr_en;
  logic [LOG2N-1:0] wr_add1;
  logic [LOG2N-1:0] wr_add2;
  logic [SW-1:0]    stage;

  modport master (
    input  start, inverse, tw_re_in, tw_im_in, bf_done,
    output busy, done, rd_en, rd_add1, rd_add2, tw_addr,
    output factor_re, factor_im, en_multi,
    output wr_en, wr_add1, wr_add2, stage
  );

  modport slave (
    output start, inverse, tw_re_in, tw_im_in, bf_done,
    input  busy, done, rd_en, rd_add1, rd_add2, tw_addr,
    input  factor_re, factor_im, en_multi,
    input  wr_en, wr_add1, wr_add2, stage
  );
endinterface

// File: rtl/fft_addr_ctrl.sv
// fft_addr_ctrl: in-place radix-2 DIT FFT sequencer. Walks stage, group and
// pair, issuing paired reads, twiddle lookups and matching write-backs.
module fft_addr_ctrl #(
  parameter int LOG2N = 3,
  parameter int TW_W  = 16
) (
  input logic        clk,
  input logic        rst,
  fft_addr_if.master bus
);
  localparam int SW = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
  localparam int AW = LOG2N;
  localparam int TA = LOG2N - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [TW_W-1:0] MOST_NEG = TW_W'(1) << (TW_W - 1);

  logic [1:0]      state;
  logic            first;
  logic            inv;
  logic            busy;
  logic            done;
  logic [AW-1:0]   k;
  logic [TA-1:0]   j;
  logic [SW-1:0]   s;
  logic [AW-1:0]   rd_add1;
  logic [AW-1:0]   rd_add2;
  logic [AW-1:0]   wr_add1;
  logic [AW-1:0]   wr_add2;
  logic [TA-1:0]   tw_addr;
  logic [TW_W-1:0] factor_re;
  logic [TW_W-1:0] factor_im;
  logic [TW_W-1:0] im_neg;

  logic [AW:0]     k_step;
  logic [AW-1:0]   half;
  logic [AW-1:0]   j_inc;
  logic [AW-1:0]   nk;
  logic [TA-1:0]   nj;
  logic [SW-1:0]   ns;
  logic [SW-1:0]   tw_sh;
  logic            wrap;
  logic            j_last;
  logic            s_last;
  logic            last;

  assign k_step = {1'b0, k} + ((AW+1)'(2) << s);
  assign half   = AW'(1) << s;
  assign j_inc  = AW'(j) + AW'(1);
  assign wrap   = k_step[AW];
  assign j_last = (j_inc == half);
  assign s_last = (s == SW'(LOG2N - 1));
  assign last   = wrap && j_last && s_last;

  // Next pair: step within the group, else next group, else next stage.
  always_comb begin
    nk = k_step[AW-1:0];
    nj = j;
    ns = s;
    if (wrap) begin
      if (j_last) begin
        nk = '0;
        nj = '0;
        ns = s + SW'(1);
      end else begin
        nk = j_inc;
        nj = j_inc[TA-1:0];
      end
    end
  end

  assign tw_sh = SW'(LOG2N - 1) - ns;

  // Conjugate needs -im; the most negative code clamps to the largest positive.
  assign im_neg = (bus.tw_im_in == MOST_NEG) ? ~MOST_NEG
                                             : (~bus.tw_im_in + TW_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      first     <= 1'b0;
      inv       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      k         <= '0;
      j         <= '0;
      s         <= '0;
      rd_add1   <= '0;
      rd_add2   <= '0;
      wr_add1   <= '0;
      wr_add2   <= '0;
      tw_addr   <= '0;
      factor_re <= '0;
      factor_im <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            inv     <= bus.inverse;
            k       <= '0;
            j       <= '0;
            s       <= '0;
            busy    <= 1'b1;
            rd_add1 <= '0;
            rd_add2 <= AW'(1);
            tw_addr <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          first <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (first) begin
            first     <= 1'b0;
            factor_re <= bus.tw_re_in;
            factor_im <= inv ? im_neg : bus.tw_im_in;
          end else if (bus.bf_done) begin
            wr_add1 <= rd_add1;
            wr_add2 <= rd_add2;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            k       <= nk;
            j       <= nj;
            s       <= ns;
            rd_add1 <= nk;
            rd_add2 <= nk + (AW'(1) << ns);
            tw_addr <= nj << tw_sh;
            state   <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = (state == ISSUE);
  assign bus.en_multi  = (state == WAIT);
  assign bus.wr_en     = (state == WRITE);
  assign bus.rd_add1   = rd_add1;
  assign bus.rd_add2   = rd_add2;
  assign bus.wr_add1   = wr_add1;
  assign bus.wr_add2   = wr_add2;
  assign bus.tw_addr   = tw_addr;
  assign bus.factor_re = factor_re;
  assign bus.factor_im = factor_im;
  assign bus.stage     = s;
endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Bench for fft_addr_ctrl: random ROM data and butterfly latency, checked
// against a stage/group/pair loop-nest reference.
`timescale 1ns/1ps
module tb_fft_addr_ctrl;
  localparam int TW_W = 16;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] tw;
    logic [7:0] st;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_addr_if #(.LOG2N(3), .TW_W(TW_W)) b ();
  fft_addr_if #(.LOG2N(4), .TW_W(TW_W)) b4 ();

  fft_addr_ctrl #(.LOG2N(3), .TW_W(TW_W)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  fft_addr_ctrl #(.LOG2N(4), .TW_W(TW_W)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int tests;
  int fails;

  logic [15:0] rom_re [4];
  logic [15:0] rom_im [4];

  // Synchronous twiddle ROM, one cycle latency.
  always @(posedge clk) begin
    b.tw_re_in <= rom_re[b.tw_addr];
    b.tw_im_in <= rom_im[b.tw_addr];
  end

  int   cyc = 0;
  int   wcnt = 0;
  int   bf_mode;
  int   bf_delay;
  logic noise;
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  ev_t  exp_q[$];
  logic [15:0] fre_q[$];
  logic [15:0] fim_q[$];
  int   wlen_q[$];
  int   n_done, n_overlap, n_early, n_multi_wr, n_gap;
  int   first_rd, last_wr, done_cyc;
  logic busy_first, busy_at_done, seen_bf, in_bf;

  // Monitor and butterfly model share one negedge process.
  always @(negedge clk) begin
    cyc++;
    if (b.rd_en) begin
      if (rd_q.size() == 0) begin
        first_rd   = cyc;
        busy_first = b.busy;
      end
      rd_q.push_back('{8'(b.rd_add1), 8'(b.rd_add2),
                       8'(b.tw_addr), 8'(b.stage)});
      seen_bf = 1'b0;
    end
    if (b.wr_en) begin
      wr_q.push_back('{8'(b.wr_add1), 8'(b.wr_add2), 8'd0, 8'd0});
      fre_q.push_back(b.factor_re);
      fim_q.push_back(b.factor_im);
      wlen_q.push_back(wcnt);
      if (!seen_bf) n_early++;
      if (b.en_multi) n_multi_wr++;
      last_wr = cyc;
    end
    if (b.rd_en && b.wr_en) n_overlap++;
    if (b.done) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = b.busy;
    end
    if (b.rd_en) in_bf = 1'b1;
    else if (b.wr_en) in_bf = 1'b0;
    else if (in_bf && !b.en_multi) n_gap++;
    if (b.rd_en) wcnt = 0;
    else if (b.en_multi) wcnt++;
    if (bf_mode == 0) b.bf_done = 1'b1;
    else if (b.en_multi) b.bf_done = (wcnt >= bf_delay);
    else b.bf_done = noise ? 1'($urandom) : 1'b0;
    if (b.en_multi && wcnt >= 2 && b.bf_done) seen_bf = 1'b1;
  end

  ev_t rd4_q[$];
  int  n4_wr, n4_done;
  logic [7:0] l4_w1, l4_w2, l4_tw;

  always @(negedge clk) begin
    if (b4.rd_en) begin
      rd4_q.push_back('{8'(b4.rd_add1), 8'(b4.rd_add2),
                        8'(b4.tw_addr), 8'(b4.stage)});
      l4_tw = 8'(b4.tw_addr);
    end
    if (b4.wr_en) begin
      n4_wr++;
      l4_w1 = 8'(b4.wr_add1);
      l4_w2 = 8'(b4.wr_add2);
    end
    if (b4.done) n4_done++;
  end

  task automatic clear_mon();
    rd_q = {}; wr_q = {}; fre_q = {}; fim_q = {}; wlen_q = {};
    n_done = 0; n_overlap = 0; n_early = 0; n_multi_wr = 0;
    n_gap = 0; in_bf = 1'b0; seen_bf = 1'b0;
    first_rd = -1; last_wr = -1; done_cyc = -1;
  endtask

  task automatic build_model(input int lg);
    exp_q = {};
    for (int s = 0; s < lg; s++)
      for (int j = 0; j < (1 << s); j++)
        for (int k = j; k < (1 << lg); k += (1 << (s + 1)))
          exp_q.push_back('{8'(k), 8'(k + (1 << s)),
                            8'(j << (lg - 1 - s)), 8'(s)});
  endtask

  task automatic rand_rom();
    for (int i = 0; i < 4; i++) begin
      rom_re[i] = 16'($urandom);
      rom_im[i] = 16'($urandom);
    end
  endtask

  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    int x;
    x = -int'($signed(v));
    if (x > 32767) x = 32767;
    return 16'(x);
  endfunction

  function automatic int rd_err();
    int e = 0;
    if (rd_q.size() != exp_q.size()) e++;
    foreach (exp_q[i])
      if (i >= rd_q.size() || rd_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic int wr_err();
    int e = 0;
    if (wr_q.size() != exp_q.size()) e++;
    foreach (exp_q[i])
      if (i >= wr_q.size() || wr_q[i].a1 !== exp_q[i].a1 ||
          wr_q[i].a2 !== exp_q[i].a2) e++;
    return e;
  endfunction

  function automatic int fac_err(input logic inv);
    int e = 0;
    logic [1:0] t;
    logic [15:0] im;
    if (fre_q.size() != exp_q.size()) e++;
    for (int i = 0; i < fre_q.size() && i < exp_q.size(); i++) begin
      t  = exp_q[i].tw[1:0];
      im = inv ? sat_neg(rom_im[t]) : rom_im[t];
      if (fre_q[i] !== rom_re[t] || fim_q[i] !== im) e++;
    end
    return e;
  endfunction

  task automatic start_pass(input logic inv);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk); #1;
    clear_mon();
    b.start   = 1'b1;
    b.inverse = inv;
    @(negedge clk); #1;
    b.start   = 1'b0;
    b.inverse = 1'($urandom);
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({b.busy, b.done, b.rd_en, b.wr_en, b.en_multi} !== 5'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b required 00000",
               {b.busy, b.done, b.rd_en, b.wr_en, b.en_multi});
    end
    tests++;
    if ({b.rd_add1, b.rd_add2, b.wr_add1, b.wr_add2, b.tw_addr} !== '0) begin
      fails++;
      $display("FAIL reset_addr: got %h required 0",
               {b.rd_add1, b.rd_add2, b.wr_add1, b.wr_add2, b.tw_addr});
    end
    tests++;
    if ({b.factor_re, b.factor_im, b.stage} !== '0) begin
      fails++;
      $display("FAIL reset_factor_stage: got %h required 0",
               {b.factor_re, b.factor_im, b.stage});
    end
    tests++;
    if ({b4.busy, b4.rd_en, b4.stage} !== '0) begin
      fails++;
      $display("FAIL reset_n16: got %b required 0",
               {b4.busy, b4.rd_en, b4.stage});
    end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    logic ok;
    bf_mode = 0;
    rand_rom();
    start_pass(1'b0);
    wait_done(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL fwd_timeout: got no done required done");
    end
    tests++;
    if (rd_err() != 0) begin
      fails++;
      $display("FAIL fwd_rd_seq: got %0d bad of %0d reads required 0 bad",
               rd_err(), rd_q.size());
    end
    tests++;
    if (wr_err() != 0 || wr_q.size() != 12) begin
      fails++;
      $display("FAIL fwd_wr_seq: got %0d writes %0d bad required 12, 0",
               wr_q.size(), wr_err());
    end
    tests++;
    if (fac_err(1'b0) != 0) begin
      fails++;
      $display("FAIL fwd_factor: got %0d bad required 0", fac_err(1'b0));
    end
    tests++;
    if (last_wr - first_rd + 1 != 48) begin
      fails++;
      $display("FAIL fwd_pass_len: got %0d cycles required 48",
               last_wr - first_rd + 1);
    end
    tests++;
    if (busy_first !== 1'b1) begin
      fails++;
      $display("FAIL fwd_busy_issue: got %b required 1", busy_first);
    end
    tests++;
    if (done_cyc != last_wr + 1 || busy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL fwd_done_time: got cyc %0d busy %b required %0d 0",
               done_cyc, busy_at_done, last_wr + 1);
    end
    @(negedge clk); #1;
    tests++;
    if (b.done !== 1'b0) begin
      fails++;
      $display("FAIL fwd_done_pulse: got %b required 0", b.done);
    end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (n_done != 1 || n_overlap != 0 || n_multi_wr != 0) begin
      fails++;
      $display("FAIL fwd_misc: got done %0d ovl %0d mwr %0d required 1 0 0",
               n_done, n_overlap, n_multi_wr);
    end
  endtask

  task automatic test_inverse();
    logic ok;
    bf_mode = 0;
    rand_rom();
    rom_im[0] = 16'h4000;
    rom_im[2] = 16'h8000;
    rom_re[2] = 16'h8000;
    start_pass(1'b1);
    wait_done(ok);
    tests++;
    if (!ok || fac_err(1'b1) != 0) begin
      fails++;
      $display("FAIL inv_factor: got done %b bad %0d required 1 0",
               ok, fac_err(1'b1));
    end
    tests++;
    if (fim_q.size() < 7 || fim_q[0] !== 16'hC000 ||
        fim_q[6] !== 16'h7FFF || fre_q[6] !== 16'h8000) begin
      fails++;
      $display("FAIL inv_sat: got %h %h re %h required c000 7fff re 8000",
               fim_q[0], fim_q[6], fre_q[6]);
    end
  endtask

  task automatic test_bf_delay();
    logic ok;
    int bad;
    bf_mode = 1;
    noise   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bf_delay = (r == 0) ? 5 : $urandom_range(2, 7);
      rand_rom();
      start_pass(1'b0);
      wait_done(ok);
      bad = 0;
      foreach (wlen_q[i]) if (wlen_q[i] != bf_delay) bad++;
      tests++;
      if (!ok || bad != 0 || wlen_q.size() != 12) begin
        fails++;
        $display("FAIL dly_wait_len: got %0d bad of %0d required 0 of 12",
                 bad, wlen_q.size());
      end
      tests++;
      if (n_early != 0 || n_gap != 0) begin
        fails++;
        $display("FAIL dly_early_wr: got early %0d gap %0d required 0 0",
                 n_early, n_gap);
      end
      tests++;
      if (rd_err() != 0 || wr_err() != 0) begin
        fails++;
        $display("FAIL dly_seq: got rd %0d wr %0d bad required 0 0",
                 rd_err(), wr_err());
      end
    end
    bf_mode = 0;
    noise   = 1'b0;
  endtask

  task automatic test_restart();
    logic ok;
    bf_mode = 0;
    start_pass(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rd_q.size() >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    b.start = 1'b1;
    @(negedge clk); #1;
    b.start = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rst6_reach: got %0d reads required 6", rd_q.size());
    end
    wait_done(ok);
    repeat (6) @(negedge clk);
    #1;
    tests++;
    if (!ok || rd_err() != 0 || wr_err() != 0) begin
      fails++;
      $display("FAIL restart_seq: got rd %0d wr %0d bad required 0 0",
               rd_err(), wr_err());
    end
    tests++;
    if (n_done != 1 || b.busy !== 1'b0) begin
      fails++;
      $display("FAIL restart_done: got %0d busy %b required 1 0",
               n_done, b.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int dcyc;
    bf_mode = 0;
    start_pass(1'b0);
    ok = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (b.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    dcyc = done_cyc;
    clear_mon();
    b.start = 1'b1;
    @(negedge clk); #1;
    b.start = 1'b0;
    tests++;
    if (!ok || first_rd != dcyc + 1) begin
      fails++;
      $display("FAIL b2b_issue: got first issue %0d required %0d",
               first_rd, dcyc + 1);
    end
    wait_done(ok);
    tests++;
    if (!ok || rd_err() != 0 || n_done != 1) begin
      fails++;
      $display("FAIL b2b_seq: got bad %0d done %0d required 0 1",
               rd_err(), n_done);
    end
  endtask

  task automatic test_abort();
    logic ok;
    bf_mode = 0;
    start_pass(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (b.en_multi && b.stage == 1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL abort_reach: got no stage1 wait required one");
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({b.busy, b.done, b.rd_en, b.wr_en, b.en_multi} !== 5'b0) begin
      fails++;
      $display("FAIL abort_strobes: got %b required 00000",
               {b.busy, b.done, b.rd_en, b.wr_en, b.en_multi});
    end
    tests++;
    if ({b.rd_add1, b.rd_add2, b.wr_add1, b.wr_add2, b.tw_addr,
         b.factor_re, b.factor_im, b.stage} !== '0) begin
      fails++;
      $display("FAIL abort_regs: got %h required 0",
               {b.rd_add1, b.rd_add2, b.wr_add1, b.wr_add2, b.tw_addr,
                b.factor_re, b.factor_im, b.stage});
    end
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (n_done != 0 || rd_q.size() != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL abort_quiet: got done %0d rd %0d wr %0d required 0",
               n_done, rd_q.size(), wr_q.size());
    end
    start_pass(1'b0);
    wait_done(ok);
    tests++;
    if (!ok || rd_q.size() == 0 || rd_q[0].a1 !== 8'd0 ||
        rd_q[0].a2 !== 8'd1 || rd_err() != 0) begin
      fails++;
      $display("FAIL abort_restart: got first (%0d,%0d) bad %0d req (0,1) 0",
               rd_q[0].a1, rd_q[0].a2, rd_err());
    end
  endtask

  task automatic test_log2n4();
    logic ok;
    build_model(4);
    rd4_q = {};
    n4_wr = 0;
    n4_done = 0;
    @(negedge clk); #1;
    b4.start = 1'b1;
    @(negedge clk); #1;
    b4.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (n4_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (!ok || n4_wr != 32 || n4_done != 1) begin
      fails++;
      $display("FAIL n16_count: got wr %0d done %0d required 32 1",
               n4_wr, n4_done);
    end
    tests++;
    if (rd4_q.size() != exp_q.size() || rd4_q != exp_q ||
        rd4_q[0].st !== 8'd0 || rd4_q[31].st !== 8'd3) begin
      fails++;
      $display("FAIL n16_seq: got %0d reads, stage order wrong required 32",
               rd4_q.size());
    end
    tests++;
    if (l4_w1 !== 8'd7 || l4_w2 !== 8'd15 || l4_tw !== 8'd7) begin
      fails++;
      $display("FAIL n16_last: got (%0d,%0d) tw %0d required (7,15) tw 7",
               l4_w1, l4_w2, l4_tw);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    b.start    = 1'b0;
    b.inverse  = 1'b0;
    b4.start   = 1'b0;
    b4.inverse = 1'b0;
    b4.bf_done = 1'b1;
    b4.tw_re_in = '0;
    b4.tw_im_in = '0;
    bf_mode  = 0;
    bf_delay = 2;
    noise    = 1'b0;
    rand_rom();
    clear_mon();
    build_model(3);
    test_reset();
    test_forward();
    test_inverse();
    test_bf_delay();
    test_restart();
    test_back_to_back();
    test_abort();
    test_log2n4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_addr_ctrl.md
# fft_addr_ctrl

Parametrised in-place radix-2 DIT FFT sequencer that replaces the loop-based RAM controller with a cycle-accurate state machine. On a start pulse it walks every stage, twiddle group and butterfly pair, and issues paired read addresses and a twiddle ROM address. It waits for the butterfly unit's completion handshake, then issues the matching paired write. It sits between the dual-port data RAM, an external synchronous twiddle ROM and the butterfly unit, and adds an inverse-FFT (conjugate twiddle) mode.

## Interface
- LOG2N, 3, log2 of FFT length N; legal range 2..12
- TW_W, 16, width of each twiddle component (signed, two's complement)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin one FFT pass; ignored while busy
- inverse  in  1  1 = IFFT (conjugate twiddles); sampled only on accepted start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after final write
- rd_en  out  1  read strobe, one cycle per butterfly
- rd_add1 / rd_add2  out  LOG2N each  read addresses of upper/lower operand
- tw_addr  out  LOG2N-1  twiddle ROM address (ROM latency 1 cycle)
- tw_re_in / tw_im_in  in  TW_W each  ROM data
- factor_re / factor_im  out  TW_W each  registered twiddle to butterfly
- en_multi  out  1  butterfly multiplier enable
- bf_done  in  1  butterfly result ready
- wr_en  out  1  write strobe, one cycle per butterfly
- wr_add1 / wr_add2  out  LOG2N each  write-back addresses
- stage  out  max(1,clog2(LOG2N))  current stage index s

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE: start=1 latches inverse, clears s/j/k, sets busy, and goes to ISSUE.
- ISSUE (1 cycle): rd_en=1, rd_add1=k, rd_add2=k+2^s, tw_addr=j<<(LOG2N-1-s). Next state is WAIT.
- WAIT: en_multi=1.
  - First WAIT cycle: factor_re<=tw_re_in. factor_im<=tw_im_in, or its negation when inverse.
  - Negation saturates: -(-2^(TW_W-1)) gives 2^(TW_W-1)-1.
  - bf_done is ignored in the first WAIT cycle and sampled from the second onward. bf_done=1 moves to WRITE.
- WRITE (1 cycle): wr_en=1, wr_add1/wr_add2 equal the addresses of the pair just read, en_multi=0.
- Counter advance, applied at the end of WRITE:
  - k+=2^(s+1).
  - If the new k>=N: k=j+1 and j++.
  - If j was 2^s-1: j=0, k=0, s++.
  - If s was LOG2N-1: this is the final pair; go to IDLE, pulse done, drop busy.
  - Otherwise go to ISSUE.
- Order per stage s: j=0..2^s-1 outer, k=j, j+2^(s+1), … <N inner. Each stage issues N/2 butterflies; a pass issues (N/2)·LOG2N butterflies.
- rd_add*/wr_add*/tw_addr hold their last value outside their strobe cycle.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, rd_en=0, wr_en=0, en_multi=0, all addresses=0, factor_re=factor_im=0, stage=0.
- Reset mid-pass aborts with no done pulse and no further strobes.
- start is accepted in IDLE only. The first ISSUE occurs in the cycle after acceptance, and busy rises in that same cycle.
- Minimum 4 cycles per butterfly (ISSUE, WAIT×2, WRITE). Minimum pass for N=8 is 48 cycles from the first ISSUE to the final WRITE inclusive.
- done is asserted in the cycle after the final WRITE, and busy=0 in that same cycle.
- start asserted in the done cycle is accepted, so back-to-back passes have no extra idle cycle.
- bf_done held high continuously gives the 4-cycle cadence. bf_done pulses outside WAIT are ignored.
- rd_en and wr_en are never high in the same cycle.

## Test plan
- LOG2N=3, forward, bf_done tied 1:
  - Read pairs must be (0,1)(2,3)(4,5)(6,7) tw0; (0,2)(4,6) tw0; (1,3)(5,7) tw2; (0,4)tw0 (1,5)tw1 (2,6)tw2 (3,7)tw3.
  - Write pairs must be identical, 12 wr_en pulses total, one done pulse.
- Inverse=1, ROM returns im=0x4000 then 0x8000: factor_im must be 0xC000 then 0x7FFF (saturated); factor_re passes unchanged.
- bf_done delayed 5 cycles per butterfly:
  - Each WAIT must last exactly 5 cycles with en_multi high throughout.
  - No wr_en may occur before bf_done.
- start pulsed again at butterfly 6 while busy: the sequence must be unchanged, with exactly one done.
- rst asserted in WAIT of stage 1: all outputs must go to 0 immediately, with no done.
- After release and a new start, the first read pair must be (0,1).
- LOG2N=4: 32 wr_en pulses, stage must step 0→3, and the last pair must be (7,15) with tw_addr=7.
